// File: rtl/spi_tft_pkg.sv
// Shared definitions for the TFT panel SPI byte transmitter:
// FSM state encoding, D/C flag values and the default SCLK divider.
package spi_tft_pkg;

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_SHIFT = 4'b0010,
        S_HOLD  = 4'b0100,
        S_ACK   = 4'b1000
    } state_t;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

    localparam int unsigned CLK_DIV_DEFAULT = 2;

endpackage

// File: rtl/spi_tft_byte_tx.sv
// Byte-level SPI mode-0 transmitter for the TFT panel: req/ack byte handshake,
// MSB-first shifting, chip select held across bytes until the end signal.
module spi_tft_byte_tx
    import spi_tft_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       tx_req_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_dc_i,
    input  logic       tx_end_i,
    output logic       tx_ack_o,
    output logic       tx_busy_o,
    output logic       lcd_sclk_o,
    output logic       lcd_mosi_o,
    output logic       lcd_cs_n_o,
    output logic       lcd_dc_o
);

    localparam logic [7:0] PHASE_LAST = 8'(CLK_DIV - 1);

    state_t     state;
    logic [7:0] phase_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;
    logic       idle_settle;
    logic       phase_done;

    assign phase_done = (phase_cnt == PHASE_LAST);
    assign tx_busy_o  = (state != S_IDLE);

    // idle_settle blanks the first IDLE edge after an ack so a requester still
    // holding req for one cycle cannot start a duplicate transfer.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state       <= S_IDLE;
            phase_cnt   <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            idle_settle <= 1'b0;
            tx_ack_o    <= 1'b0;
            lcd_sclk_o  <= 1'b0;
            lcd_mosi_o  <= 1'b0;
            lcd_cs_n_o  <= 1'b1;
            lcd_dc_o    <= DC_CMD;
        end else begin
            tx_ack_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    idle_settle <= 1'b0;
                    if (tx_req_i && !idle_settle) begin
                        shift_reg  <= tx_data_i;
                        lcd_dc_o   <= tx_dc_i;
                        lcd_cs_n_o <= 1'b0;
                        lcd_mosi_o <= tx_data_i[7];
                        lcd_sclk_o <= 1'b0;
                        phase_cnt  <= '0;
                        bit_cnt    <= 3'd7;
                        state      <= S_SHIFT;
                    end else if (tx_end_i) begin
                        lcd_cs_n_o <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (phase_done) begin
                        phase_cnt <= '0;
                        if (!lcd_sclk_o) begin
                            lcd_sclk_o <= 1'b1;
                        end else begin
                            // Falling SCLK: next bit goes out so it is stable for a full low phase.
                            lcd_sclk_o <= 1'b0;
                            if (bit_cnt == 3'd0) begin
                                state <= S_HOLD;
                            end else begin
                                bit_cnt    <= bit_cnt - 3'd1;
                                shift_reg  <= {shift_reg[6:0], 1'b0};
                                lcd_mosi_o <= shift_reg[6];
                            end
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 8'd1;
                    end
                end
                S_HOLD: begin
                    if (phase_done) begin
                        phase_cnt <= '0;
                        tx_ack_o  <= 1'b1;
                        state     <= S_ACK;
                    end else begin
                        phase_cnt <= phase_cnt + 8'd1;
                    end
                end
                S_ACK: begin
                    idle_settle <= 1'b1;
                    state       <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_tft_byte_tx.sv
// Self-checking bench for spi_tft_byte_tx: scoreboard of expected bytes popped
// on each ack, plus a second instance with CLK_DIV=1.
module tb_spi_tft_byte_tx;
    import spi_tft_pkg::*;

    localparam int DIV_A = 2;
    localparam int DIV_B = 1;

    logic       clk;
    logic       rst_n;

    logic       a_req, a_dc, a_end;
    logic [7:0] a_data;
    logic       a_ack, a_busy, a_sclk, a_mosi, a_cs_n, a_dc_o;

    logic       b_req, b_dc, b_end;
    logic [7:0] b_data;
    logic       b_ack, b_busy, b_sclk, b_mosi, b_cs_n, b_dc_o;

    int         tests;
    int         fails;
    int         accepts;
    int         cs_high;
    bit         watch_cs;
    logic [8:0] exp_q[$];
    logic [8:0] b_exp_q[$];

    spi_tft_byte_tx #(.CLK_DIV(DIV_A)) dut_a (
        .sys_clk    (clk),
        .sys_rst_n  (rst_n),
        .tx_req_i   (a_req),
        .tx_data_i  (a_data),
        .tx_dc_i    (a_dc),
        .tx_end_i   (a_end),
        .tx_ack_o   (a_ack),
        .tx_busy_o  (a_busy),
        .lcd_sclk_o (a_sclk),
        .lcd_mosi_o (a_mosi),
        .lcd_cs_n_o (a_cs_n),
        .lcd_dc_o   (a_dc_o)
    );

    spi_tft_byte_tx #(.CLK_DIV(DIV_B)) dut_b (
        .sys_clk    (clk),
        .sys_rst_n  (rst_n),
        .tx_req_i   (b_req),
        .tx_data_i  (b_data),
        .tx_dc_i    (b_dc),
        .tx_end_i   (b_end),
        .tx_ack_o   (b_ack),
        .tx_busy_o  (b_busy),
        .lcd_sclk_o (b_sclk),
        .lcd_mosi_o (b_mosi),
        .lcd_cs_n_o (b_cs_n),
        .lcd_dc_o   (b_dc_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard side for instance A: assembles MOSI on SCLK rises, checks each ack.
    task automatic monitor_a();
        logic       prev_sclk = 1'b0;
        logic       prev_busy = 1'b0;
        logic       prev_ack  = 1'b0;
        logic [7:0] acc = '0;
        logic [8:0] e;
        int         nbits = 0;
        int         cs_bad = 0;
        int         cyc = 0;
        int         accept_cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_sclk = 1'b0;
                prev_busy = 1'b0;
                prev_ack  = 1'b0;
                acc       = '0;
                nbits     = 0;
                cs_bad    = 0;
            end else begin
                if (a_sclk && !prev_sclk) begin
                    acc = {acc[6:0], a_mosi};
                    nbits++;
                    if (a_cs_n !== 1'b0) cs_bad++;
                end
                if (a_busy && !prev_busy) begin
                    accept_cyc = cyc;
                    accepts++;
                end
                if (watch_cs && a_cs_n !== 1'b0) cs_high++;
                if (a_ack) begin
                    tests++;
                    if (prev_ack !== 1'b0) begin
                        fails++;
                        $display("[TB] FAIL ack_width: ack high %0d cycles in a row, required 1", 2);
                    end
                    if (!prev_ack) begin
                        tests++;
                        if (exp_q.size() == 0) begin
                            fails++;
                            $display("[TB] FAIL unexpected_ack: ack with no pending request, byte 0x%02h", acc);
                        end else begin
                            e = exp_q.pop_front();
                            tests += 4;
                            if (acc !== e[7:0] || nbits != 8) begin
                                fails++;
                                $display("[TB] FAIL mosi_byte: got 0x%02h in %0d bits, expected 0x%02h in 8 bits", acc, nbits, e[7:0]);
                            end
                            if (a_dc_o !== e[8]) begin
                                fails++;
                                $display("[TB] FAIL dc_flag: got %b, expected %b", a_dc_o, e[8]);
                            end
                            if (cyc - accept_cyc != 17 * DIV_A) begin
                                fails++;
                                $display("[TB] FAIL ack_latency: got %0d cycles, expected %0d", cyc - accept_cyc, 17 * DIV_A);
                            end
                            if (cs_bad != 0) begin
                                fails++;
                                $display("[TB] FAIL cs_during_byte: CS high on %0d SCLK rises, expected 0", cs_bad);
                            end
                        end
                    end
                    acc    = '0;
                    nbits  = 0;
                    cs_bad = 0;
                end
                prev_sclk = a_sclk;
                prev_busy = a_busy;
                prev_ack  = a_ack;
            end
        end
    endtask

    // Requester model: holds req through the ack cycle, drops it one cycle later.
    task automatic send_a(input logic [7:0] d, input logic dc);
        int n = 0;
        bit got = 0;
        exp_q.push_back({dc, d});
        @(negedge clk);
        a_req  = 1'b1;
        a_data = d;
        a_dc   = dc;
        while (!got && n < 400) begin
            @(negedge clk);
            n++;
            if (a_busy) begin
                a_data = ~d;
                a_dc   = ~dc;
            end
            if (a_ack) got = 1;
        end
        if (!got) begin
            tests++;
            fails++;
            $display("[TB] FAIL send_timeout: no ack for 0x%02h after %0d cycles", d, n);
        end
        @(negedge clk);
        a_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests += 7;
        if (a_sclk !== 1'b0) begin fails++; $display("[TB] FAIL reset_sclk: got %b, expected 0", a_sclk); end
        if (a_mosi !== 1'b0) begin fails++; $display("[TB] FAIL reset_mosi: got %b, expected 0", a_mosi); end
        if (a_cs_n !== 1'b1) begin fails++; $display("[TB] FAIL reset_cs_n: got %b, expected 1", a_cs_n); end
        if (a_dc_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_dc: got %b, expected 0", a_dc_o); end
        if (a_ack !== 1'b0) begin fails++; $display("[TB] FAIL reset_ack: got %b, expected 0", a_ack); end
        if (a_busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b, expected 0", a_busy); end
        if (b_cs_n !== 1'b1) begin fails++; $display("[TB] FAIL reset_b_cs_n: got %b, expected 1", b_cs_n); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_cmd();
        send_a(8'h3A, DC_CMD);
        tests++;
        if (a_cs_n !== 1'b0) begin fails++; $display("[TB] FAIL single_cs_after: got %b, expected 0", a_cs_n); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes[5] = '{8'h2A, 8'h00, 8'h00, 8'h01, 8'h3F};
        cs_high  = 0;
        watch_cs = 1'b1;
        a_end    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_a(bytes[i], (i == 0) ? DC_CMD : DC_DATA);
            if (i < 2) begin
                tests++;
                if (a_dc_o !== ((i == 0) ? DC_CMD : DC_DATA)) begin
                    fails++;
                    $display("[TB] FAIL b2b_dc_toggle: byte %0d dc got %b, expected %b", i, a_dc_o, (i == 0) ? DC_CMD : DC_DATA);
                end
            end
        end
        watch_cs = 1'b0;
        tests++;
        if (cs_high != 0) begin fails++; $display("[TB] FAIL b2b_cs_low: CS high for %0d cycles, expected 0", cs_high); end
    endtask

    task automatic test_req_drop();
        int base = accepts;
        send_a(8'h11, DC_DATA);
        send_a(8'h22, DC_DATA);
        send_a(8'h33, DC_DATA);
        repeat (8) @(negedge clk);
        tests++;
        if (accepts - base != 3) begin
            fails++;
            $display("[TB] FAIL req_drop_accepts: got %0d accepts, expected 3", accepts - base);
        end
    endtask

    task automatic test_end_release();
        int  n = 0;
        int  csb = 0;
        bit  got = 0;
        exp_q.push_back({DC_CMD, 8'h29});
        @(negedge clk);
        a_req  = 1'b1;
        a_data = 8'h29;
        a_dc   = DC_CMD;
        a_end  = 1'b0;
        while (!got && n < 400) begin
            @(negedge clk);
            n++;
            if (a_busy) a_end = 1'b1;
            if (a_busy && a_cs_n !== 1'b0) csb++;
            if (a_ack) got = 1;
        end
        tests += 4;
        if (!got) begin fails++; $display("[TB] FAIL end_timeout: no ack after %0d cycles", n); end
        if (csb != 0) begin fails++; $display("[TB] FAIL end_ignored_busy: CS high %0d busy cycles, expected 0", csb); end
        @(negedge clk);
        a_req = 1'b0;
        @(negedge clk);
        if (a_cs_n !== 1'b1) begin fails++; $display("[TB] FAIL end_cs_rise: got %b, expected 1", a_cs_n); end
        if (a_sclk !== 1'b0) begin fails++; $display("[TB] FAIL end_sclk_idle: got %b, expected 0", a_sclk); end
        a_end = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int   rises = 0;
        int   n = 0;
        logic prev;
        @(negedge clk);
        a_req  = 1'b1;
        a_data = 8'hA5;
        a_dc   = DC_DATA;
        prev   = a_sclk;
        while (rises < 3 && n < 200) begin
            @(negedge clk);
            n++;
            if (a_sclk && !prev) rises++;
            prev = a_sclk;
        end
        a_req = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        tests += 7;
        if (rises != 3) begin fails++; $display("[TB] FAIL mid_rises: got %0d SCLK rises, expected 3", rises); end
        if (a_cs_n !== 1'b1) begin fails++; $display("[TB] FAIL mid_cs_n: got %b, expected 1", a_cs_n); end
        if (a_sclk !== 1'b0) begin fails++; $display("[TB] FAIL mid_sclk: got %b, expected 0", a_sclk); end
        if (a_mosi !== 1'b0) begin fails++; $display("[TB] FAIL mid_mosi: got %b, expected 0", a_mosi); end
        if (a_busy !== 1'b0) begin fails++; $display("[TB] FAIL mid_busy: got %b, expected 0", a_busy); end
        if (a_ack !== 1'b0) begin fails++; $display("[TB] FAIL mid_ack: got %b, expected 0", a_ack); end
        if (a_dc_o !== 1'b0) begin fails++; $display("[TB] FAIL mid_dc: got %b, expected 0", a_dc_o); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_a(8'h55, DC_DATA);
    endtask

    task automatic test_clkdiv1_req_end();
        int         n = 0;
        int         accept_n = -1;
        int         last_rise = -1;
        int         bad_period = 0;
        int         nbits = 0;
        int         cs_bad = 0;
        bit         got = 0;
        logic       prev_sclk = 1'b0;
        logic [7:0] acc = '0;
        logic [8:0] e;
        b_exp_q.push_back({DC_DATA, 8'hC3});
        @(negedge clk);
        b_req  = 1'b1;
        b_end  = 1'b1;
        b_data = 8'hC3;
        b_dc   = DC_DATA;
        while (!got && n < 100) begin
            @(negedge clk);
            n++;
            if (b_busy) begin
                b_data = 8'h3C;
                b_dc   = DC_CMD;
            end
            if (accept_n < 0 && b_busy) begin
                accept_n = n;
                tests++;
                if (b_cs_n !== 1'b0) begin fails++; $display("[TB] FAIL b_req_wins: CS got %b, expected 0", b_cs_n); end
            end
            if (b_sclk && !prev_sclk) begin
                if (last_rise >= 0 && n - last_rise != 2) bad_period++;
                last_rise = n;
                acc = {acc[6:0], b_mosi};
                nbits++;
            end
            if (b_busy && b_cs_n !== 1'b0) cs_bad++;
            if (b_ack) got = 1;
            prev_sclk = b_sclk;
        end
        tests += 5;
        e = b_exp_q.pop_front();
        if (!got) begin fails++; $display("[TB] FAIL b_timeout: no ack after %0d cycles", n); end
        if (acc !== e[7:0] || nbits != 8) begin
            fails++;
            $display("[TB] FAIL b_byte: got 0x%02h in %0d bits, expected 0x%02h in 8 bits", acc, nbits, e[7:0]);
        end
        if (b_dc_o !== e[8]) begin fails++; $display("[TB] FAIL b_dc: got %b, expected %b", b_dc_o, e[8]); end
        if (n - accept_n != 17 * DIV_B) begin
            fails++;
            $display("[TB] FAIL b_latency: got %0d cycles, expected %0d", n - accept_n, 17 * DIV_B);
        end
        if (bad_period != 0 || cs_bad != 0) begin
            fails++;
            $display("[TB] FAIL b_period_cs: %0d bad SCLK periods, %0d CS-high cycles, expected 0 and 0", bad_period, cs_bad);
        end
        @(negedge clk);
        b_req = 1'b0;
        @(negedge clk);
        tests++;
        if (b_cs_n !== 1'b1) begin fails++; $display("[TB] FAIL b_end_release: CS got %b, expected 1", b_cs_n); end
        b_end = 1'b0;
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        accepts  = 0;
        cs_high  = 0;
        watch_cs = 1'b0;
        rst_n    = 1'b0;
        a_req    = 1'b0;
        a_data   = '0;
        a_dc     = 1'b0;
        a_end    = 1'b0;
        b_req    = 1'b0;
        b_data   = '0;
        b_dc     = 1'b0;
        b_end    = 1'b0;
        fork
            monitor_a();
        join_none
        test_reset();
        test_single_cmd();
        test_back_to_back();
        test_req_drop();
        test_end_release();
        test_reset_mid();
        test_clkdiv1_req_end();
        repeat (4) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL pending_bytes: %0d expected bytes never acked, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
